// File: rtl/rrf_flag_wb.sv
// rtl/rrf_flag_wb.sv - retirement flag register write-side controller
//
// Purpose: picks the youngest flag-writing slot of each accepted retire group,
// holds the result in a small in-order circular queue and presents the head
// entry to the single flag RRF write port under a write_ready handshake.
//
// Optional feature macro: RRF_FLAG_WB_MERGE_EN
//   When defined, a flag-writing group whose thread matches the newest queued
//   entry (with at least two entries held) overwrites that entry in place
//   instead of allocating a new one.
//
// Ports:
//   clk              in   clock, all state on posedge
//   rst              in   synchronous active-low reset
//   ret_valid        in   retire group present
//   ret_ready        out  group can be accepted this cycle
//   ret_flag_wen     in   [RET_WIDTH]   per-slot flag write enable
//   ret_flags        in   [RET_WIDTH*DATA_WIDTH] per-slot flag values
//   ret_thread       in   thread of the whole group
//   write0_data      out  [DATA_WIDTH] head entry flag value
//   write0_wen       out  head entry valid (write request)
//   write_thread     out  head entry thread
//   write_ready      in   arbiter accepts the head entry this cycle
//   pend_cnt         out  [$clog2(DEPTH)+1] entries held
//   pend_thread_mask out  [2] bit t set if any held entry belongs to thread t

module rrf_flag_wb #(
  parameter int DATA_WIDTH = 6,
  parameter int RET_WIDTH  = 4,
  parameter int DEPTH      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ret_valid,
  output logic                            ret_ready,
  input  logic [RET_WIDTH-1:0]            ret_flag_wen,
  input  logic [RET_WIDTH*DATA_WIDTH-1:0] ret_flags,
  input  logic                            ret_thread,
  output logic [DATA_WIDTH-1:0]           write0_data,
  output logic                            write0_wen,
  output logic                            write_thread,
  input  logic                            write_ready,
  output logic [$clog2(DEPTH):0]          pend_cnt,
  output logic [1:0]                      pend_thread_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      thr_q;

  logic                  has_wen;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  enq;
  logic                  deq;
  logic                  merge;
  logic                  alloc;

  // Youngest writer wins: later (higher) slots overwrite earlier picks.
  always_comb begin
    has_wen  = |ret_flag_wen;
    sel_data = '0;
    for (int i = 0; i < RET_WIDTH; i++) begin
      if (ret_flag_wen[i]) sel_data = ret_flags[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Gating with rst keeps the port quiet during the reset cycle even though
  // the queue state is only cleared at the edge.
  assign ret_ready  = rst && (count < CW'(DEPTH));
  assign write0_wen = rst && (count != '0);

  assign enq = ret_valid && ret_ready && has_wen;
  assign deq = write0_wen && write_ready;

`ifdef RRF_FLAG_WB_MERGE_EN
  logic [PW-1:0] tail_prev;
  assign tail_prev = tail - PW'(1);
  // With two or more entries the newest one is never the head, so the
  // entry currently on the write port is never modified.
  assign merge = enq && (count >= CW'(2)) && (thr_q[tail_prev] == ret_thread);
`else
  assign merge = 1'b0;
`endif

  assign alloc = enq && !merge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      thr_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      if (alloc) begin
        data_q[tail] <= sel_data;
        thr_q[tail]  <= ret_thread;
        tail         <= tail + PW'(1);
      end
`ifdef RRF_FLAG_WB_MERGE_EN
      if (merge) data_q[tail_prev] <= sel_data;
`endif
      if (deq) head <= head + PW'(1);
      case ({alloc, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign write0_data  = data_q[head];
  assign write_thread = thr_q[head];
  assign pend_cnt     = count;

  always_comb begin
    logic [PW-1:0] idx;
    pend_thread_mask = '0;
    idx              = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) pend_thread_mask[thr_q[idx]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rrf_flag_wb.sv
// tb/tb_rrf_flag_wb.sv - self-checking bench for rrf_flag_wb

module tb_rrf_flag_wb;

  localparam int DW = 6;
  localparam int RW = 4;
  localparam int DP = 2;
  localparam int CW = $clog2(DP) + 1;

  logic              clk;
  logic              rst;
  logic              ret_valid;
  logic              ret_ready;
  logic [RW-1:0]     ret_flag_wen;
  logic [RW*DW-1:0]  ret_flags;
  logic              ret_thread;
  logic [DW-1:0]     write0_data;
  logic              write0_wen;
  logic              write_thread;
  logic              write_ready;
  logic [CW-1:0]     pend_cnt;
  logic [1:0]        pend_thread_mask;

  int tests = 0;
  int fails = 0;

  // model: each entry is {thread, data}
  logic [DW:0]   mq [$];
  logic [DW-1:0] mlog [$];
  logic [DW-1:0] dlog [$];

  rrf_flag_wb #(.DATA_WIDTH(DW), .RET_WIDTH(RW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_flag_wen(ret_flag_wen), .ret_flags(ret_flags), .ret_thread(ret_thread),
    .write0_data(write0_data), .write0_wen(write0_wen), .write_thread(write_thread),
    .write_ready(write_ready), .pend_cnt(pend_cnt), .pend_thread_mask(pend_thread_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] model_mask();
    logic [1:0] m;
    m = 2'b00;
    foreach (mq[i]) m[mq[i][DW]] = 1'b1;
    return m;
  endfunction

  function automatic logic [RW*DW-1:0] slot0(input logic [DW-1:0] d);
    logic [RW*DW-1:0] f;
    f = '0;
    f[DW-1:0] = d;
    return f;
  endfunction

  // Drive one cycle with rst high; the model retires/accepts at the edge.
  task automatic step(input logic v, input logic [RW-1:0] w, input logic [RW*DW-1:0] f,
                      input logic t, input logic wr);
    logic          acc;
    logic          do_deq;
    logic [DW-1:0] sel;
    ret_valid = v; ret_flag_wen = w; ret_flags = f; ret_thread = t; write_ready = wr;
    #1;
    if (write0_wen && write_ready) dlog.push_back(write0_data);
    acc    = v && (mq.size() < DP);
    do_deq = wr && (mq.size() != 0);
    if (acc && (w != '0)) begin
      sel = '0;
      for (int i = RW - 1; i >= 0; i--) begin
        if (w[i]) begin
          sel = f[i*DW +: DW];
          break;
        end
      end
`ifdef RRF_FLAG_WB_MERGE_EN
      if (mq.size() >= 2 && mq[mq.size()-1][DW] == t) mq[mq.size()-1] = {t, sel};
      else mq.push_back({t, sel});
`else
      mq.push_back({t, sel});
`endif
    end
    if (do_deq) begin
      mlog.push_back(mq[0][DW-1:0]);
      void'(mq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic wr);
    step(1'b0, '0, '0, 1'b0, wr);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (ret_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ret_ready); end
    @(posedge clk); #1;
    tests++; if (write0_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %b exp 0", write0_wen); end
    tests++; if (pend_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
    tests++; if (pend_thread_mask !== 2'b00) begin fails++; $display("FAIL reset_mask got %b exp 00", pend_thread_mask); end
    tests++; if (write0_data !== '0 || write_thread !== 1'b0) begin
      fails++; $display("FAIL reset_data got %h/%b exp 00/0", write0_data, write_thread); end
    mq.delete();
    rst = 1'b1;
    #1;
    tests++; if (ret_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b exp 1", ret_ready); end
  endtask

  task automatic test_single();
    step(1'b1, 4'b0101, {6'h00, 6'h2A, 6'h00, 6'h11}, 1'b1, 1'b0);
    tests++; if (write0_wen !== 1'b1) begin fails++; $display("FAIL single_wen got %b exp 1", write0_wen); end
    tests++; if (write0_data !== 6'h2A) begin fails++; $display("FAIL single_data got %h exp 2a", write0_data); end
    tests++; if (write_thread !== 1'b1) begin fails++; $display("FAIL single_thread got %b exp 1", write_thread); end
    tests++; if (pend_thread_mask !== 2'b10) begin fails++; $display("FAIL single_mask got %b exp 10", pend_thread_mask); end
    idle(1'b1);
    tests++; if (write0_wen !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", write0_wen); end
  endtask

  task automatic test_no_writer();
    step(1'b1, 4'b0000, {6'h3F, 6'h3F, 6'h3F, 6'h3F}, 1'b0, 1'b1);
    tests++; if (write0_wen !== 1'b0) begin fails++; $display("FAIL nowr_wen got %b exp 0", write0_wen); end
    tests++; if (pend_cnt !== '0) begin fails++; $display("FAIL nowr_cnt got %0d exp 0", pend_cnt); end
    tests++; if (ret_ready !== 1'b1) begin fails++; $display("FAIL nowr_ready got %b exp 1", ret_ready); end
  endtask

  task automatic test_backpressure();
    dlog.delete(); mlog.delete();
    step(1'b1, 4'b0001, slot0(6'd1), 1'b0, 1'b0);
    step(1'b1, 4'b0001, slot0(6'd2), 1'b0, 1'b0);
    tests++; if (ret_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b exp 0", ret_ready); end
    tests++; if (pend_cnt !== CW'(2)) begin fails++; $display("FAIL bp_cnt got %0d exp 2", pend_cnt); end
    step(1'b1, 4'b0001, slot0(6'd3), 1'b0, 1'b0);
    tests++; if (write0_data !== 6'd1) begin fails++; $display("FAIL bp_hold got %h exp 01", write0_data); end
    // release: offer group 3 until the model says it was taken
    for (int k = 0; k < 4; k++) step(k < 2, 4'b0001, slot0(6'd3), 1'b0, 1'b1);
    tests++; if (dlog.size() != 3) begin fails++; $display("FAIL bp_nwrites got %0d exp 3", dlog.size()); end
    else begin
      tests++; if (dlog[0] !== 6'd1 || dlog[1] !== 6'd2 || dlog[2] !== 6'd3) begin
        fails++; $display("FAIL bp_order got %h %h %h exp 01 02 03", dlog[0], dlog[1], dlog[2]); end
    end
  endtask

  task automatic test_simul();
    step(1'b1, 4'b0001, slot0(6'h15), 1'b0, 1'b0);
    step(1'b1, 4'b1000, {6'h2C, 18'h0}, 1'b1, 1'b1);
    tests++; if (pend_cnt !== CW'(1)) begin fails++; $display("FAIL simul_cnt got %0d exp 1", pend_cnt); end
    tests++; if (write0_data !== 6'h2C || write_thread !== 1'b1) begin
      fails++; $display("FAIL simul_data got %h/%b exp 2c/1", write0_data, write_thread); end
    idle(1'b1);
  endtask

  task automatic test_merge();
    dlog.delete(); mlog.delete();
    step(1'b1, 4'b0001, slot0(6'h0A), 1'b0, 1'b0);
    step(1'b1, 4'b0001, slot0(6'h0B), 1'b0, 1'b0);
    step(1'b1, 4'b0001, slot0(6'h0C), 1'b0, 1'b0);
    tests++; if (pend_cnt !== CW'(mq.size())) begin fails++; $display("FAIL merge_cnt got %0d exp %0d", pend_cnt, mq.size()); end
    tests++; if (pend_cnt !== CW'(2)) begin fails++; $display("FAIL merge_cnt2 got %0d exp 2", pend_cnt); end
    tests++; if (ret_ready !== (mq.size() < DP)) begin fails++; $display("FAIL merge_ready got %b", ret_ready); end
    for (int k = 0; k < 5; k++) step(k < 2, 4'b0001, slot0(6'h0C), 1'b0, 1'b1);
    tests++; if (dlog != mlog) begin fails++; $display("FAIL merge_order got %p exp %p", dlog, mlog); end
    tests++; if (dlog.size() != 3) begin fails++; $display("FAIL merge_nwrites got %0d exp 3", dlog.size()); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'b0001, slot0(6'h33), 1'b1, 1'b0);
    step(1'b1, 4'b0001, slot0(6'h1F), 1'b0, 1'b0);
    tests++; if (pend_cnt !== CW'(2)) begin fails++; $display("FAIL mid_pre_cnt got %0d exp 2", pend_cnt); end
    rst = 1'b0; ret_valid = 1'b0; write_ready = 1'b1;
    #1;
    tests++; if (write0_wen !== 1'b0) begin fails++; $display("FAIL mid_rst_wen got %b exp 0", write0_wen); end
    @(posedge clk); #1;
    mq.delete();
    rst = 1'b1;
    #1;
    tests++; if (write0_wen !== 1'b0) begin fails++; $display("FAIL mid_wen got %b exp 0", write0_wen); end
    tests++; if (pend_cnt !== '0) begin fails++; $display("FAIL mid_cnt got %0d exp 0", pend_cnt); end
    tests++; if (pend_thread_mask !== 2'b00) begin fails++; $display("FAIL mid_mask got %b exp 00", pend_thread_mask); end
    dlog.delete();
    for (int k = 0; k < 3; k++) idle(1'b1);
    tests++; if (dlog.size() != 0) begin fails++; $display("FAIL mid_stale_write got %0d exp 0", dlog.size()); end
  endtask

  task automatic test_random();
    logic [RW*DW-1:0] f;
    dlog.delete(); mlog.delete();
    for (int n = 0; n < 300; n++) begin
      f = RW*DW'({$urandom, $urandom});
      step(1'($urandom_range(0, 3) != 0), RW'($urandom), f, 1'($urandom), 1'($urandom_range(0, 2) != 0));
      tests++; if (ret_ready !== (mq.size() < DP)) begin fails++; $display("FAIL rnd_ready cyc %0d got %b", n, ret_ready); end
      tests++; if (write0_wen !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_wen cyc %0d got %b", n, write0_wen); end
      tests++; if (pend_cnt !== CW'(mq.size())) begin fails++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, pend_cnt, mq.size()); end
      tests++; if (pend_thread_mask !== model_mask()) begin
        fails++; $display("FAIL rnd_mask cyc %0d got %b exp %b", n, pend_thread_mask, model_mask()); end
      if (mq.size() != 0) begin
        tests++; if ({write_thread, write0_data} !== mq[0]) begin
          fails++; $display("FAIL rnd_head cyc %0d got %h exp %h", n, {write_thread, write0_data}, mq[0]); end
      end
    end
    tests++; if (dlog != mlog) begin fails++; $display("FAIL rnd_log got %0d writes exp %0d", dlog.size(), mlog.size()); end
  endtask

  initial begin
    rst = 1'b0; ret_valid = 1'b0; ret_flag_wen = '0; ret_flags = '0;
    ret_thread = 1'b0; write_ready = 1'b0;
    test_reset();
    test_single();
    test_no_writer();
    test_backpressure();
    test_simul();
    test_merge();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
